// File: rtl/vs1003_spi_responder.sv
// VS1003-style SCI/SDI responder: decodes SCI register writes and SDI audio
// bytes from an MP3 player, buffers audio in a byte FIFO and drives DREQ.
module vs1003_spi_responder #(
  parameter int unsigned FIFO_DEPTH      = 64,
  parameter int unsigned DREQ_FREE       = 32,
  parameter int unsigned SOFT_RST_CYCLES = 1000
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          XRSET,
  input  logic                          XCS,
  input  logic                          XDCS,
  input  logic                          SCLK,
  input  logic                          SI,
  output logic                          DREQ,
  output logic [15:0]                   mode_reg,
  output logic [15:0]                   vol_reg,
  output logic                          vol_upd,
  output logic [7:0]                    byte_data,
  output logic                          byte_valid,
  input  logic                          byte_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned HW = $clog2(SOFT_RST_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(SOFT_RST_CYCLES);
  localparam logic [15:0]   MODE_RST  = 16'h0800;
  localparam logic [7:0]    OP_WRITE  = 8'h02;
  localparam logic [7:0]    ADDR_MODE = 8'h00;
  localparam logic [7:0]    ADDR_VOL  = 8'h0B;
  // Idle pin levels: XRSET, XCS, XDCS high; SCLK, SI low
  localparam logic [4:0]    SYNC_RST  = 5'b11100;

  typedef enum logic [1:0] {ST_HOLD, ST_IDLE, ST_SCI, ST_SDI} state_t;

  state_t          state;
  logic [HW-1:0]   hold_cnt;
  logic [5:0]      bit_cnt;
  logic [31:0]     shreg;
  logic            wait_high;

  logic [4:0]      sync1;
  logic [4:0]      sync2;
  logic            sclk_q;
  logic            xrset_s;
  logic            xcs_s;
  logic            xdcs_s;
  logic            sclk_s;
  logic            si_s;

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [7:0]      mem [FIFO_DEPTH];

  logic            sclk_rise;
  logic            sci_write;
  logic            sm_reset;
  logic            push;
  logic [7:0]      push_byte;
  logic            flush;
  logic            pop;
  logic            full;
  logic            do_push;
  logic            free_ok;
  logic [LW-1:0]   level_nxt;

  // Two-flop synchronizers for every pin from the player, plus SCLK history
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1  <= SYNC_RST;
      sync2  <= SYNC_RST;
      sclk_q <= 1'b0;
    end else begin
      sync1  <= {XRSET, XCS, XDCS, SCLK, SI};
      sync2  <= sync1;
      sclk_q <= sync2[1];
    end
  end

  assign xrset_s = sync2[4];
  assign xcs_s   = sync2[3];
  assign xdcs_s  = sync2[2];
  assign sclk_s  = sync2[1];
  assign si_s    = sync2[0];

  // Frame decode, FIFO control and flow-control decisions for this cycle
  always_comb begin
    sclk_rise = sclk_s & ~sclk_q;
    sci_write = (state == ST_SCI) && xcs_s && (bit_cnt == 6'd32) &&
                (shreg[31:24] == OP_WRITE);
    sm_reset  = sci_write && (shreg[23:16] == ADDR_MODE) && shreg[2];
    push      = (state == ST_SDI) && xrset_s && !xdcs_s && sclk_rise &&
                (bit_cnt[2:0] == 3'd7);
    push_byte = {shreg[6:0], si_s};
    flush     = ~xrset_s | sm_reset;
    pop       = byte_valid & byte_ready;
    full      = (fifo_level == LW'(FIFO_DEPTH));
    do_push   = push & (~full | pop);
    level_nxt = fifo_level + LW'(do_push) - LW'(pop);
    free_ok   = (LW'(FIFO_DEPTH) - fifo_level) >= LW'(DREQ_FREE);
  end

  // FIFO pointers, occupancy and overflow flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      byte_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push && !do_push) begin
        overflow <= 1'b1;
      end
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_level <= '0;
        byte_valid <= 1'b0;
      end else begin
        if (do_push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        fifo_level <= level_nxt;
        byte_valid <= (level_nxt != '0);
      end
    end
  end

  // FIFO storage; contents are only meaningful below the level count
  always_ff @(posedge CLK) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_byte;
    end
  end

  assign byte_data = mem[rd_ptr];

  // Link state machine: soft-reset hold, frame dispatch, SCI decode, SDI shift
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_HOLD;
      hold_cnt  <= HOLD_LOAD;
      bit_cnt   <= '0;
      shreg     <= '0;
      wait_high <= 1'b0;
      mode_reg  <= MODE_RST;
      vol_reg   <= '0;
      vol_upd   <= 1'b0;
      DREQ      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      vol_upd <= 1'b0;
      if (!xrset_s) begin
        // Hardware reset from the player: restart the hold window
        state     <= ST_HOLD;
        hold_cnt  <= HOLD_LOAD;
        bit_cnt   <= '0;
        wait_high <= 1'b0;
        mode_reg  <= MODE_RST;
        vol_reg   <= '0;
        DREQ      <= 1'b0;
      end else begin
        case (state)
          ST_HOLD: begin
            if (hold_cnt == '0) begin
              state <= ST_IDLE;
              DREQ  <= free_ok;
            end else begin
              hold_cnt <= hold_cnt - HW'(1);
              DREQ     <= 1'b0;
            end
          end
          ST_IDLE: begin
            DREQ    <= free_ok;
            bit_cnt <= '0;
            if (wait_high) begin
              if (xcs_s && xdcs_s) begin
                wait_high <= 1'b0;
              end
            end else if (!xcs_s && !xdcs_s) begin
              frame_err <= 1'b1;
              wait_high <= 1'b1;
            end else if (!xcs_s) begin
              state <= ST_SCI;
            end else if (!xdcs_s) begin
              state <= ST_SDI;
            end
          end
          ST_SCI: begin
            DREQ <= free_ok;
            if (xcs_s) begin
              state <= ST_IDLE;
              if (!sci_write) begin
                frame_err <= 1'b1;
              end else if (shreg[23:16] == ADDR_MODE) begin
                // SM_RESET is self-clearing; a set bit starts a soft reset
                mode_reg <= shreg[15:0] & ~16'h0004;
                if (sm_reset) begin
                  state    <= ST_HOLD;
                  hold_cnt <= HOLD_LOAD;
                  DREQ     <= 1'b0;
                end
              end else if (shreg[23:16] == ADDR_VOL) begin
                vol_reg <= shreg[15:0];
                vol_upd <= 1'b1;
              end
            end else if (sclk_rise) begin
              shreg <= {shreg[30:0], si_s};
              // Saturate past 32 so long frames are still rejected
              if (bit_cnt != 6'd33) begin
                bit_cnt <= bit_cnt + 6'd1;
              end
            end
          end
          ST_SDI: begin
            DREQ <= free_ok;
            if (xdcs_s) begin
              state <= ST_IDLE;
            end else if (sclk_rise) begin
              shreg   <= {shreg[30:0], si_s};
              bit_cnt <= (bit_cnt[2:0] == 3'd7) ? 6'd0 : bit_cnt + 6'd1;
            end
          end
          default: state <= ST_HOLD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vs1003_spi_responder.sv
// Bench for vs1003_spi_responder: SCI frame table plus SDI/FIFO sequences
// checked through an expected-byte scoreboard.
module tb_vs1003_spi_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        XRSET;
  logic        XCS;
  logic        XDCS;
  logic        SCLK;
  logic        SI;
  logic        DREQ;
  logic [15:0] mode_reg;
  logic [15:0] vol_reg;
  logic        vol_upd;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic [6:0]  fifo_level;
  logic        overflow;
  logic        frame_err;

  int checks   = 0;
  int failures = 0;
  int vol_pulses = 0;
  logic [7:0] q [$];

  typedef struct {
    logic [31:0] frame;
    int          nbits;
    logic [15:0] mode;
    logic [15:0] vol;
    int          upd;
    logic        ferr;
  } vec_t;

  vec_t vecs [7];

  vs1003_spi_responder dut (
    .CLK(CLK), .RST(RST), .XRSET(XRSET), .XCS(XCS), .XDCS(XDCS),
    .SCLK(SCLK), .SI(SI), .DREQ(DREQ), .mode_reg(mode_reg),
    .vol_reg(vol_reg), .vol_upd(vol_upd), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready),
    .fifo_level(fifo_level), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Count vol_upd pulses
  always @(negedge CLK) if (vol_upd) vol_pulses++;

  // Consumer side: each pop must match the oldest expected byte
  always @(negedge CLK) begin
    if (!RST && byte_valid && byte_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected actual=%h required=none", byte_data);
      end else begin
        chk("pop_data", 32'(byte_data), 32'(q.pop_front()));
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_ready(input logic v);
    @(posedge CLK);
    #1;
    byte_ready = v;
  endtask

  task automatic spi_bit(input logic b);
    SI = b;
    #50;
    SCLK = 1'b1;
    #50;
    SCLK = 1'b0;
  endtask

  task automatic sci_frame(input logic [31:0] f, input int n);
    XCS = 1'b0;
    #100;
    for (int i = 0; i < n; i++) spi_bit(f[31-i]);
    #100;
    XCS = 1'b1;
    #200;
  endtask

  task automatic sdi_open();
    XDCS = 1'b0;
    #100;
  endtask

  task automatic sdi_close();
    #100;
    XDCS = 1'b1;
    #200;
  endtask

  // Expected byte goes into the scoreboard unless the FIFO model is full
  task automatic sdi_byte(input logic [7:0] b);
    if (q.size() < 64) q.push_back(b);
    for (int i = 0; i < 8; i++) spi_bit(b[7-i]);
  endtask

  task automatic do_reset(input bit timing);
    RST = 1'b1;
    q.delete();
    wait_clk(3);
    chk("rst_dreq", 32'(DREQ), 32'd0);
    chk("rst_mode", 32'(mode_reg), 32'h0800);
    chk("rst_vol", 32'(vol_reg), 32'h0000);
    chk("rst_valid", 32'(byte_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_flags", 32'({overflow, frame_err}), 32'd0);
    RST = 1'b0;
    if (timing) begin
      wait_clk(995);
      chk("hold_dreq_low", 32'(DREQ), 32'd0);
      wait_clk(10);
      chk("hold_dreq_high", 32'(DREQ), 32'd1);
    end else begin
      wait_clk(1010);
    end
  endtask

  initial begin
    int p0;
    RST = 1'b1; XRSET = 1'b1; XCS = 1'b1; XDCS = 1'b1;
    SCLK = 1'b0; SI = 1'b0; byte_ready = 1'b0;

    vecs[0] = '{32'h020B2020, 32, 16'h0800, 16'h2020, 1, 1'b0};
    vecs[1] = '{32'h020B2020, 32, 16'h0800, 16'h2020, 1, 1'b0};
    vecs[2] = '{32'h02000810, 32, 16'h0810, 16'h2020, 0, 1'b0};
    vecs[3] = '{32'h02051234, 32, 16'h0810, 16'h2020, 0, 1'b0};
    vecs[4] = '{32'h020BFFFF, 32, 16'h0810, 16'hFFFF, 1, 1'b0};
    vecs[5] = '{32'h03000000, 32, 16'h0810, 16'hFFFF, 0, 1'b1};
    vecs[6] = '{32'h020B1111, 20, 16'h0810, 16'hFFFF, 0, 1'b1};

    // Power-up hold and reset values
    do_reset(1'b1);
    chk("post_mode", 32'(mode_reg), 32'h0800);

    // SCI frame table
    foreach (vecs[i]) begin
      p0 = vol_pulses;
      sci_frame(vecs[i].frame, vecs[i].nbits);
      chk("sci_mode", 32'(mode_reg), 32'(vecs[i].mode));
      chk("sci_vol", 32'(vol_reg), 32'(vecs[i].vol));
      chk("sci_vol_upd", 32'(vol_pulses - p0), 32'(vecs[i].upd));
      chk("sci_ferr", 32'(frame_err), 32'(vecs[i].ferr));
    end

    // Two 16-bit words in one window, then a dangling partial byte
    do_reset(1'b0);
    sdi_open();
    sdi_byte(8'hA5); sdi_byte(8'h5A); sdi_byte(8'h12); sdi_byte(8'h34);
    for (int i = 0; i < 4; i++) spi_bit(1'b1);
    sdi_close();
    chk("sdi_level4", 32'(fifo_level), 32'd4);
    chk("sdi_head", 32'(byte_data), 32'hA5);
    chk("sdi_no_ferr", 32'(frame_err), 32'd0);
    set_ready(1'b1);
    wait_clk(10);
    chk("sdi_level0", 32'(fifo_level), 32'd0);
    chk("sdi_valid0", 32'(byte_valid), 32'd0);
    chk("sdi_sb_empty", 32'(q.size()), 32'd0);
    set_ready(1'b0);

    // DREQ threshold and overflow with a stalled consumer
    sdi_open();
    for (int i = 0; i < 32; i++) sdi_byte(8'(i * 7 + 3));
    sdi_close();
    chk("dreq_at32", 32'(DREQ), 32'd1);
    sdi_open();
    sdi_byte(8'hC3);
    sdi_close();
    chk("level33", 32'(fifo_level), 32'd33);
    chk("dreq_at33", 32'(DREQ), 32'd0);
    sdi_open();
    for (int i = 0; i < 7; i++) sdi_byte(8'(8'h80 + i));
    sdi_close();
    chk("level40", 32'(fifo_level), 32'd40);
    chk("no_ovf40", 32'(overflow), 32'd0);
    sdi_open();
    for (int i = 0; i < 30; i++) sdi_byte(8'(8'h40 + i));
    sdi_close();
    chk("level_full", 32'(fifo_level), 32'd64);
    chk("ovf_set", 32'(overflow), 32'd1);
    set_ready(1'b1);
    wait_clk(80);
    chk("drain_level", 32'(fifo_level), 32'd0);
    chk("drain_sb", 32'(q.size()), 32'd0);
    chk("drain_dreq", 32'(DREQ), 32'd1);
    set_ready(1'b0);

    // SM_RESET with bytes queued
    sdi_open();
    for (int i = 0; i < 10; i++) sdi_byte(8'(8'h10 + i));
    sdi_close();
    chk("pre_smr_level", 32'(fifo_level), 32'd10);
    sci_frame(32'h02000804, 32);
    q.delete();
    chk("smr_level", 32'(fifo_level), 32'd0);
    chk("smr_mode", 32'(mode_reg), 32'h0800);
    chk("smr_dreq_low", 32'(DREQ), 32'd0);
    wait_clk(980);
    chk("smr_dreq_hold", 32'(DREQ), 32'd0);
    wait_clk(30);
    chk("smr_dreq_high", 32'(DREQ), 32'd1);

    // Short SCI frame
    do_reset(1'b0);
    p0 = vol_pulses;
    sci_frame(32'h020B5555, 20);
    chk("short_ferr", 32'(frame_err), 32'd1);
    chk("short_vol", 32'(vol_reg), 32'h0000);
    chk("short_upd", 32'(vol_pulses - p0), 32'd0);

    // Both chip selects low together
    do_reset(1'b0);
    XCS = 1'b0; XDCS = 1'b0;
    #100;
    for (int i = 0; i < 8; i++) spi_bit(1'b1);
    #100;
    XCS = 1'b1; XDCS = 1'b1;
    #200;
    chk("both_ferr", 32'(frame_err), 32'd1);
    chk("both_level", 32'(fifo_level), 32'd0);
    chk("both_valid", 32'(byte_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
